// File: rtl/matrix_scan_pkg.sv
// Shared types and sizes for the LED matrix scan receiver.
package matrix_scan_pkg;

  localparam int unsigned ROWS   = 8;
  localparam int unsigned COLS   = 8;
  localparam int unsigned ROW_W  = 3;
  localparam int unsigned COMM_W = 4;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned FCNT_W = 8;

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } scan_state_e;

  typedef struct packed {
    logic [COLS-1:0] r;
    logic [COLS-1:0] g;
    logic [COLS-1:0] b;
  } rgb_row_t;

  // Column drivers are active-low; stored pixels are active-high.
  function automatic rgb_row_t pixels_on(input logic [COLS-1:0] r,
                                         input logic [COLS-1:0] g,
                                         input logic [COLS-1:0] b);
    rgb_row_t px;
    px.r = ~r;
    px.g = ~g;
    px.b = ~b;
    return px;
  endfunction

endpackage

// File: rtl/matrix_scan_rx_if.sv
// Scan input / frame read-port bundle for matrix_scan_rx.
interface matrix_scan_rx_if;
  import matrix_scan_pkg::*;

  logic [COMM_W-1:0] comm;
  logic [COLS-1:0]   data_r;
  logic [COLS-1:0]   data_g;
  logic [COLS-1:0]   data_b;
  logic [ROW_W-1:0]  rd_row;
  logic [COLS-1:0]   rd_r;
  logic [COLS-1:0]   rd_g;
  logic [COLS-1:0]   rd_b;
  logic              frame_valid;
  logic              seq_err;
  logic              locked;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output comm, data_r, data_g, data_b, rd_row,
    input  rd_r, rd_g, rd_b, frame_valid, seq_err, locked, frame_cnt
  );

  modport slave (
    input  comm, data_r, data_g, data_b, rd_row,
    output rd_r, rd_g, rd_b, frame_valid, seq_err, locked, frame_cnt
  );

endinterface

// File: rtl/matrix_scan_row_detect.sv
// Tracks comm changes and emits a sample strobe once a row select has been
// stable for SETTLE clocks.
module matrix_scan_row_detect
  import matrix_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic [COMM_W-1:0] comm_i,
  output logic              sample_c_o,
  output logic [ROW_W-1:0]  row_c_o
);

  logic [COMM_W-1:0] comm_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              changed_c;

  assign changed_c = (comm_i != comm_q);

  // Any change restarts settling; blanking or a row change aborts a pending one.
  always_comb begin
    cnt_d = cnt_q;
    if (changed_c) begin
      cnt_d = comm_i[COMM_W-1] ? CNT_W'(SETTLE) : '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      comm_q <= '0;
      cnt_q  <= '0;
    end else begin
      comm_q <= comm_i;
      cnt_q  <= cnt_d;
    end
  end

  assign sample_c_o = !changed_c && (cnt_q == CNT_W'(1));
  assign row_c_o    = comm_q[ROW_W-1:0];

endmodule

// File: rtl/matrix_scan_rx.sv
// LED matrix scan receiver: rebuilds RGB frames from a row-scanned bus.
// Build option MATRIX_SCAN_RX_DBUF_EN selects separate back/front frame buffers.
module matrix_scan_rx
  import matrix_scan_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             clear_n,
  matrix_scan_rx_if.slave  bus
);

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  scan_state_e       state_q, state_d;
  logic [ROW_W-1:0]  exp_q, exp_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;
  logic              fv_q, fv_d;
  logic              se_q, se_d;
  logic              sample_c;
  logic [ROW_W-1:0]  row_c;
  logic              store_c, publish_c, discard_c;
  rgb_row_t          px_c;
  rgb_row_t          rd_q;

  matrix_scan_row_detect #(.SETTLE(SETTLE)) u_row_detect (
    .clk        (clk),
    .clear_n    (clear_n),
    .comm_i     (bus.comm),
    .sample_c_o (sample_c),
    .row_c_o    (row_c)
  );

  assign px_c = pixels_on(bus.data_r, bus.data_g, bus.data_b);

  // Frame sequencer: lock on row 0, expect rows in order, publish on the last row.
  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    fcnt_d    = fcnt_q;
    fv_d      = 1'b0;
    se_d      = 1'b0;
    store_c   = 1'b0;
    publish_c = 1'b0;
    discard_c = 1'b0;
    if (sample_c) begin
      case (state_q)
        HUNT: begin
          if (row_c == '0) begin
            store_c = 1'b1;
            exp_d   = ROW_W'(1);
            state_d = CAPTURE;
          end
        end
        CAPTURE: begin
          if (row_c == exp_q) begin
            store_c = 1'b1;
            if (row_c == LAST_ROW) begin
              publish_c = 1'b1;
              fv_d      = 1'b1;
              fcnt_d    = fcnt_q + FCNT_W'(1);
              exp_d     = '0;
            end else begin
              exp_d = exp_q + ROW_W'(1);
            end
          end else begin
            se_d      = 1'b1;
            discard_c = 1'b1;
            // A stray row 0 is a fresh frame start, so relock immediately.
            if (row_c == '0) begin
              store_c = 1'b1;
              exp_d   = ROW_W'(1);
            end else begin
              state_d = HUNT;
              exp_d   = '0;
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= HUNT;
      exp_q   <= '0;
      fcnt_q  <= '0;
      fv_q    <= 1'b0;
      se_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      fcnt_q  <= fcnt_d;
      fv_q    <= fv_d;
      se_q    <= se_d;
    end
  end

`ifdef MATRIX_SCAN_RX_DBUF_EN
  rgb_row_t back_q  [ROWS];
  rgb_row_t front_q [ROWS];

  // Rows assemble in the back buffer; the front copy only moves at publish.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (discard_c) back_q[i] <= '0;
        if (store_c && (row_c == ROW_W'(i))) back_q[i] <= px_c;
        if (publish_c) front_q[i] <= (row_c == ROW_W'(i)) ? px_c : back_q[i];
      end
      rd_q <= front_q[bus.rd_row];
    end
  end
`else
  rgb_row_t buf_q [ROWS];
  logic     unused_c;

  assign unused_c = publish_c | discard_c;

  // Single buffer: every accepted row is readable straight away.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        buf_q[i] <= '0;
      end
      rd_q <= '0;
    end else begin
      for (int unsigned i = 0; i < ROWS; i++) begin
        if (store_c && (row_c == ROW_W'(i))) buf_q[i] <= px_c;
      end
      rd_q <= buf_q[bus.rd_row];
    end
  end
`endif

  assign bus.rd_r        = rd_q.r;
  assign bus.rd_g        = rd_q.g;
  assign bus.rd_b        = rd_q.b;
  assign bus.frame_valid = fv_q;
  assign bus.seq_err     = se_q;
  assign bus.locked      = (state_q == CAPTURE);
  assign bus.frame_cnt   = fcnt_q;

endmodule

// File: doc/matrix_scan_rx.md
MATRIX_SCAN_RX -- requirements
Module: matrix_scan_rx

Interface
REQ-001 SETTLE, default 2: clk cycles after a comm change before row data is sampled (1..15).
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 clear_n  in  1  reset; asynchronous, active-low.
REQ-004 comm  in  4  scan select; bit3=1 enables row, bits2:0 = row index.
REQ-005 data_r, data_g, data_b  in  8 each  row pixel columns; active-low (0 = LED on).
REQ-006 rd_row  in  3  read-port row select.
REQ-007 rd_r, rd_g, rd_b  out  8 each  stored pixels for rd_row; active-high (1 = on).
REQ-008 frame_valid  out  1  one-cycle pulse: complete frame published.
REQ-009 seq_err  out  1  one-cycle pulse: out-of-order row detected.
REQ-010 locked  out  1  high while in CAPTURE.
REQ-011 frame_cnt  out  8  published-frame count; wraps 255->0.

Function
REQ-012 Row event: comm differs from its value on the previous cycle and comm[3]=1; a new change during settle restarts the count.
REQ-013 Sample data_* inverted exactly SETTLE cycles after the row event, only if comm is unchanged throughout.
REQ-014 comm[3]=0 (blanking): no sample, no error, state and expected-row index unchanged.
REQ-015 States: HUNT, CAPTURE.
REQ-016 HUNT: samples of rows 1..7 discarded silently; a row-0 sample is stored, expected=1, go to CAPTURE.
REQ-017 CAPTURE: sample with row==expected is stored to back buffer, expected increments.
REQ-018 CAPTURE: sample with row!=expected pulses seq_err, discards back buffer, goes to HUNT; if that row is 0, it is stored and re-enters CAPTURE with expected=1 on the next cycle.
REQ-019 Storing row 7 publishes back to front buffer, pulses frame_valid one cycle later, increments frame_cnt, sets expected=0, stays in CAPTURE.
REQ-020 Repeated comm value (no change) produces no row event and no duplicate sample.
REQ-021 rd_* registered: reflect front buffer row rd_row one cycle after rd_row is applied.
REQ-022 Publish and read in the same cycle: read returns the pre-publish data; new data visible the following cycle.
REQ-023 frame_valid and seq_err never assert in the same cycle.

Reset
REQ-024 clear_n low: state HUNT, expected=0, settle counter 0, comm history 0, both buffers 0, rd_* 0, frame_valid 0, seq_err 0, locked 0, frame_cnt 0.
REQ-025 Reset mid-frame discards partial data; no frame_valid or seq_err pulse on reset release.

Configuration
REQ-026 Macro MATRIX_SCAN_RX_DBUF_EN defined: separate back and front buffers; front changes only at publish.
REQ-027 Macro undefined: single buffer written at each sample, visible to rd_* immediately; seq_err discards nothing; frame_valid and frame_cnt behave identically.

Structure
REQ-028 Package matrix_scan_pkg holds ROWS=8, COLS=8, the state enum (HUNT, CAPTURE), and the RGB row struct (three 8-bit fields).
REQ-029 Sub-module matrix_scan_row_detect holds comm history, change detect, settle counter; outputs a one-cycle sample strobe and the row index.

Verification
REQ-030 Reset, then comm 8..15 in order, each held 10 cycles, data_b=8'hFE on every row -> frame_valid once, frame_cnt=1, rd_b=8'h01 on all rows.
REQ-031 Locked, then comm 8,9,11 -> seq_err pulse at the row-3 sample, locked=0, front buffer unchanged (DBUF_EN).
REQ-032 comm toggles 9->10 after 1 cycle with SETTLE=2 -> only row 2 is sampled; no row-1 write.
REQ-033 Insert comm=0 blanking between rows 4 and 5 -> no error; frame completes, frame_valid=1.
REQ-034 Drive clear_n low after row 5 sample -> all outputs 0; next full frame yields frame_cnt=1.
REQ-035 Run 256 consecutive frames -> frame_cnt reads 0 after the 256th frame_valid.
